// File: rtl/byte_serial_word_adder.sv
// byte_serial_word_adder
// Adds two WORD_BYTES-wide operands plus carry-in one byte per cycle, LSB
// first, through an 8-bit ripple adder. The inter-byte carry is registered.
// The result is the full-width sum modulo 2^(8*WORD_BYTES).
// Optional build macro: BYTE_ADDER_COUT_EN adds a registered 'cout' port
// that carries the final byte's carry-out alongside the sum.
module byte_serial_word_adder #(
  parameter int WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*WORD_BYTES-1:0]   a,
  input  logic [8*WORD_BYTES-1:0]   b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*WORD_BYTES-1:0]   sum,
  output logic                      busy
`ifdef BYTE_ADDER_COUT_EN
  ,
  output logic                      cout
`endif
);

  localparam int W = 8 * WORD_BYTES;
  localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] sum_q, sum_d;
  logic         carry_q, carry_d;
  logic [2:0]   idx_q, idx_d;
`ifdef BYTE_ADDER_COUT_EN
  logic         cout_q, cout_d;
`endif

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] byte_sum;
  logic [8:0] carry_chain;

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (idx_q == 3'(k)) begin
        a_byte = a_q[8*k +: 8];
        b_byte = b_q[8*k +: 8];
      end
    end
  end

  // Eight chained full adders seeded with the registered carry.
  always_comb begin
    byte_sum       = 8'h00;
    carry_chain    = 9'h000;
    carry_chain[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      byte_sum[i]      = a_byte[i] ^ b_byte[i] ^ carry_chain[i];
      carry_chain[i+1] = (a_byte[i] & b_byte[i]) |
                         (a_byte[i] & carry_chain[i]) |
                         (b_byte[i] & carry_chain[i]);
    end
  end

  // Sequencer: capture operands, walk the bytes, then hold the result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef BYTE_ADDER_COUT_EN
    cout_d  = cout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = 3'd0;
          state_d = ST_ADD;
`ifdef BYTE_ADDER_COUT_EN
          cout_d  = 1'b0;
`endif
        end
      end
      ST_ADD: begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (idx_q == 3'(k)) begin
            sum_d[8*k +: 8] = byte_sum;
          end
        end
        carry_d = carry_chain[8];
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
`ifdef BYTE_ADDER_COUT_EN
          cout_d  = carry_chain[8];
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= 3'd0;
`ifdef BYTE_ADDER_COUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef BYTE_ADDER_COUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
    sum       = sum_q;
`ifdef BYTE_ADDER_COUT_EN
    cout      = cout_q;
`endif
  end

endmodule

// File: tb/tb_byte_serial_word_adder.sv
// Testbench for byte_serial_word_adder. Drives operand sets through the
// handshake, predicts each sum with a wide-add model and compares results
// from a scoreboard queue as the DUT hands them downstream. A second
// instance with WORD_BYTES=2 covers the narrow configuration.
module tb_byte_serial_word_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         busy;
`ifdef BYTE_ADDER_COUT_EN
  logic         cout;
  logic         cout2;
`endif

  logic         in_valid2;
  logic         in_ready2;
  logic [15:0]  a2;
  logic [15:0]  b2;
  logic         out_valid2;
  logic         out_ready2;
  logic [15:0]  sum2;
  logic         busy2;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  logic [W:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  byte_serial_word_adder #(.WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
`ifdef BYTE_ADDER_COUT_EN
    , .cout(cout)
`endif
  );

  byte_serial_word_adder #(.WORD_BYTES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .busy(busy2)
`ifdef BYTE_ADDER_COUT_EN
    , .cout(cout2)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the values disagree.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one operand set, wait (bounded) for acceptance, queue the prediction.
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                               input logic op_cin);
    logic hs;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    for (int n = 0; n < 60; n++) begin
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (done) begin
      exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin});
    end else begin
      checkOutput("in_handshake_timeout", 64'd0, 64'd1);
    end
  endtask

  // Count cycles from the handshake cycle until out_valid is seen.
  task automatic waitValid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // Bounded wait until every queued prediction has been matched.
  task automatic waitDrain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: match every accepted result and watch for dropped valid.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checkOutput("valid_held", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          checkOutput("sum", 64'(sum), 64'(e[W-1:0]));
`ifdef BYTE_ADDER_COUT_EN
          checkOutput("cout", 64'(cout), 64'(e[W]));
`endif
        end
      end
      prev_valid <= out_valid;
      prev_ready <= out_ready;
    end
  end

  // Main stimulus sequence.
  initial begin
    int cyc;
    int base;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    a2         = '0;
    b2         = '0;
    out_ready2 = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic add with latency and single-cycle valid pulse.
    $display("[TB] basic add");
    applyStimulus(32'h12345678, 32'h11111111, 1'b0);
    checkOutput("busy_in_add", 64'(busy), 64'd1);
    checkOutput("in_ready_in_add", 64'(in_ready), 64'd0);
    waitValid(cyc);
    checkOutput("latency", 64'(cyc), 64'd5);
    @(posedge clk);
    #1;
    checkOutput("valid_one_cycle", 64'(out_valid), 64'd0);
    checkOutput("ready_after_out", 64'(in_ready), 64'd1);
    waitDrain();

    // Full carry ripple, both through b and through cin.
    $display("[TB] carry ripple");
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0);
    waitDrain();
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1);
    waitDrain();
    applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1);
    waitDrain();

    // Backpressure: result and valid held, new operands refused.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0);
    waitValid(cyc);
    in_valid = 1'b1;
    a        = 32'hDEADBEEF;
    b        = 32'h01020304;
    cin      = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_sum", 64'(sum), 64'h23456789);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    base      = out_count;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_one_transfer", 64'(out_count - base), 64'd1);
    checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
    waitDrain();

    // Asynchronous reset in the second ADD cycle aborts the operation.
    $display("[TB] reset mid-add");
    applyStimulus(32'hAAAA5555, 32'h5555AAAA, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_sum", 64'(sum), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = out_count;
    applyStimulus(32'h00000001, 32'h00000002, 1'b0);
    waitDrain();
    checkOutput("post_rst_count", 64'(out_count - base), 64'd1);

    // Back-to-back operand sets with the sink always ready.
    $display("[TB] back-to-back");
    base = out_count;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0);
    applyStimulus(32'h00000001, 32'h00000002, 1'b0);
    waitDrain();
    checkOutput("b2b_count", 64'(out_count - base), 64'd2);

    // Narrow configuration: two bytes, carry discarded.
    $display("[TB] WORD_BYTES=2");
    in_valid2 = 1'b1;
    a2        = 16'h80FF;
    b2        = 16'h8001;
    checkOutput("w2_in_ready", 64'(in_ready2), 64'd1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    a2        = 16'h0000;
    cyc       = 1;
    while (!out_valid2 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("w2_latency", 64'(cyc), 64'd3);
    checkOutput("w2_sum", 64'(sum2), 64'h0100);
`ifdef BYTE_ADDER_COUT_EN
    checkOutput("w2_cout", 64'(cout2), 64'd1);
`endif
    @(posedge clk);
    #1;
    checkOutput("w2_done", 64'(out_valid2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
